// File: rtl/sc_fifo_prog_pkg.sv
// Shared types and helpers for sc_fifo_prog: level-flag state, pointer wrap and
// parameter legality check.
package sc_fifo_prog_pkg;

   typedef struct packed {
      logic full;
      logic almost_full;
      logic almost_empty;
   } flag_state_t;

   localparam flag_state_t FlagsReset = '{full: 1'b0, almost_full: 1'b0, almost_empty: 1'b1};

   // Explicit compare so non-power-of-two depths wrap at DEPTH-1.
   function automatic logic [31:0] ptr_wrap(input logic [31:0] ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
   endfunction

   function automatic bit params_ok(input int unsigned depth, input int unsigned afull_lvl,
                                    input int unsigned aempty_lvl, input int unsigned cnt_width);
      return (depth >= 2) && (afull_lvl >= 1) && (afull_lvl <= depth) &&
             (aempty_lvl <= depth - 1) && (cnt_width == $clog2(depth + 1));
   endfunction

endpackage

// File: rtl/sc_fifo_prog_if.sv
// Handshake/data bundle for sc_fifo_prog; signal names are from the FIFO's view.
// ovf_o/udf_o exist only when SC_FIFO_PROG_ERR_FLAGS_EN is defined.
interface sc_fifo_prog_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = 4
);
   logic                  flush_i;
   logic                  wr_i;
   logic [DATA_WIDTH-1:0] wr_data_i;
   logic                  rd_i;
   logic [DATA_WIDTH-1:0] rd_data_o;
   logic [CNT_WIDTH-1:0]  used_words_o;
   logic                  full_o;
   logic                  empty_o;
   logic                  almost_full_o;
   logic                  almost_empty_o;
`ifdef SC_FIFO_PROG_ERR_FLAGS_EN
   logic                  ovf_o;
   logic                  udf_o;
`endif

   modport master (
      output flush_i, wr_i, wr_data_i, rd_i,
      input  rd_data_o, used_words_o, full_o, empty_o, almost_full_o, almost_empty_o
`ifdef SC_FIFO_PROG_ERR_FLAGS_EN
      , input ovf_o, udf_o
`endif
   );

   modport slave (
      input  flush_i, wr_i, wr_data_i, rd_i,
      output rd_data_o, used_words_o, full_o, empty_o, almost_full_o, almost_empty_o
`ifdef SC_FIFO_PROG_ERR_FLAGS_EN
      , output ovf_o, udf_o
`endif
   );

endinterface

// File: rtl/sc_fifo_prog_ram.sv
// Simple dual-port RAM, synchronous read with read enable, any depth, array not reset.
module sc_fifo_prog_ram #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sc_fifo_prog.sv
// Single-clock FWFT FIFO with registered output, any depth, programmable level flags
// and flush. Sticky ovf_o/udf_o are built only with SC_FIFO_PROG_ERR_FLAGS_EN.
module sc_fifo_prog
   import sc_fifo_prog_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned AFULL_LVL  = DEPTH - 1,
   parameter int unsigned AEMPTY_LVL = 1,
   parameter int unsigned CNT_WIDTH  = $clog2(DEPTH + 1)
) (
   input logic           clk_i,
   input logic           rst_i,
   sc_fifo_prog_if.slave bus_io
);

   localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
   localparam logic [CNT_WIDTH-1:0] DepthCnt  = CNT_WIDTH'(DEPTH);
   localparam logic [CNT_WIDTH-1:0] AfullCnt  = CNT_WIDTH'(AFULL_LVL);
   localparam logic [CNT_WIDTH-1:0] AemptyCnt = CNT_WIDTH'(AEMPTY_LVL);

   if (!params_ok(DEPTH, AFULL_LVL, AEMPTY_LVL, CNT_WIDTH)) begin : g_bad_params
      $error("sc_fifo_prog: illegal DEPTH/AFULL_LVL/AEMPTY_LVL/CNT_WIDTH combination");
   end

   logic [PTR_WIDTH-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, mem_cnt;
   logic                  out_valid_q, out_valid_d;
   logic                  ram_valid_q, ram_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d, ram_rdata;
   flag_state_t           flags_q, flags_d;
   logic                  wr_req, rd_req, mem_has, load_out, ram_re;

   // Words still in the array = total minus the RAM read register and output register.
   always_comb begin
      wr_req   = bus_io.wr_i & ~flags_q.full & ~bus_io.flush_i;
      rd_req   = bus_io.rd_i & out_valid_q & ~bus_io.flush_i;
      mem_cnt  = cnt_q - CNT_WIDTH'(ram_valid_q) - CNT_WIDTH'(out_valid_q);
      mem_has  = (mem_cnt != '0);
      load_out = ram_valid_q & (~out_valid_q | rd_req) & ~bus_io.flush_i;
      ram_re   = mem_has & (~ram_valid_q | load_out) & ~bus_io.flush_i;
   end

   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      cnt_d       = cnt_q;
      ram_valid_d = ram_valid_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      if (wr_req) begin
         wptr_d = PTR_WIDTH'(ptr_wrap(32'(wptr_q), DEPTH));
      end
      if (ram_re) begin
         rptr_d = PTR_WIDTH'(ptr_wrap(32'(rptr_q), DEPTH));
      end

      if (wr_req && !rd_req) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end else if (!wr_req && rd_req) begin
         cnt_d = cnt_q - CNT_WIDTH'(1);
      end

      if (ram_re) begin
         ram_valid_d = 1'b1;
      end else if (load_out) begin
         ram_valid_d = 1'b0;
      end

      if (load_out) begin
         out_valid_d = 1'b1;
         out_data_d  = ram_rdata;
      end else if (rd_req) begin
         out_valid_d = 1'b0;
      end

      // Flush keeps the stale output word; it is don't-care while empty.
      if (bus_io.flush_i) begin
         wptr_d      = '0;
         rptr_d      = '0;
         cnt_d       = '0;
         ram_valid_d = 1'b0;
         out_valid_d = 1'b0;
      end

      flags_d.full         = (cnt_d == DepthCnt);
      flags_d.almost_full  = (cnt_d >= AfullCnt);
      flags_d.almost_empty = (cnt_d <= AemptyCnt);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         cnt_q       <= '0;
         ram_valid_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         flags_q     <= FlagsReset;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         cnt_q       <= cnt_d;
         ram_valid_q <= ram_valid_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         flags_q     <= flags_d;
      end
   end

   sc_fifo_prog_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (PTR_WIDTH)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (wr_req),
      .waddr_i (wptr_q),
      .wdata_i (bus_io.wr_data_i),
      .re_i    (ram_re),
      .raddr_i (rptr_q),
      .rdata_o (ram_rdata)
   );

   assign bus_io.rd_data_o      = out_data_q;
   assign bus_io.used_words_o   = cnt_q;
   assign bus_io.full_o         = flags_q.full;
   assign bus_io.empty_o        = ~out_valid_q;
   assign bus_io.almost_full_o  = flags_q.almost_full;
   assign bus_io.almost_empty_o = flags_q.almost_empty;

`ifdef SC_FIFO_PROG_ERR_FLAGS_EN
   logic ovf_q, ovf_d, udf_q, udf_d;

   always_comb begin
      ovf_d = ovf_q | (bus_io.wr_i & flags_q.full);
      udf_d = udf_q | (bus_io.rd_i & ~out_valid_q);
      if (bus_io.flush_i) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign bus_io.ovf_o = ovf_q;
   assign bus_io.udf_o = udf_q;
`endif

endmodule

// File: tb/tb_sc_fifo_prog.sv
// Self-checking bench for sc_fifo_prog (DEPTH=5, AFULL_LVL=3, AEMPTY_LVL=1): vector table
// plus scoreboard-checked sequences for streaming, flush, error flags and async reset.
module tb_sc_fifo_prog;

   localparam int unsigned DW     = 8;
   localparam int unsigned DEPTH  = 5;
   localparam int unsigned AFULL  = 3;
   localparam int unsigned AEMPTY = 1;
   localparam int unsigned CW     = $clog2(DEPTH + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;

   sc_fifo_prog_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) fifo_if ();

   sc_fifo_prog #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .AFULL_LVL  (AFULL),
      .AEMPTY_LVL (AEMPTY)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .bus_io (fifo_if.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit             wr;
      bit             rd;
      logic [DW-1:0]  data;
      int unsigned    exp_cnt;
      bit             exp_full;
      bit             exp_empty;
      bit             exp_af;
      bit             exp_ae;
   } vec_t;

   vec_t          vecs[11];
   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] sb_q[$];
   int unsigned   m_cnt = 0;
   bit            m_ovf = 1'b0;
   bit            m_udf = 1'b0;
   int            wr_cnt;
   int            pops;
   bit            seen;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_used"}, fifo_if.used_words_o, 0);
      check({tag, "_full"}, fifo_if.full_o, 0);
      check({tag, "_empty"}, fifo_if.empty_o, 1);
      check({tag, "_afull"}, fifo_if.almost_full_o, 0);
      check({tag, "_aempty"}, fifo_if.almost_empty_o, 1);
      check({tag, "_rd_data"}, fifo_if.rd_data_o, 0);
`ifdef SC_FIFO_PROG_ERR_FLAGS_EN
      check({tag, "_ovf"}, fifo_if.ovf_o, 0);
      check({tag, "_udf"}, fifo_if.udf_o, 0);
`endif
   endtask

   // One clock: drive, settle the model, pop the scoreboard on accepted reads, then check.
   task automatic cycle(input bit wr, input bit rd, input bit fl, input logic [DW-1:0] d);
      bit            was_full, was_empty, wr_acc, rd_acc;
      logic [DW-1:0] exp_d;
      fifo_if.wr_i      = wr;
      fifo_if.rd_i      = rd;
      fifo_if.flush_i   = fl;
      fifo_if.wr_data_i = d;
      was_full  = (m_cnt == DEPTH);
      was_empty = fifo_if.empty_o;
      wr_acc    = wr && !was_full && !fl;
      rd_acc    = rd && !was_empty && !fl;
      if (rd_acc) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pop_unexpected: got word %0h, expected no word", fifo_if.rd_data_o);
         end else begin
            exp_d = sb_q.pop_front();
            check("rd_data", fifo_if.rd_data_o, exp_d);
         end
      end
      if (fl) begin
         sb_q.delete();
         m_cnt = 0;
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         if (wr_acc) sb_q.push_back(d);
         if (wr_acc && !rd_acc) m_cnt++;
         else if (rd_acc && !wr_acc) m_cnt--;
         if (wr && was_full) m_ovf = 1'b1;
         if (rd && was_empty) m_udf = 1'b1;
      end
      @(posedge clk);
      #1;
      fifo_if.wr_i    = 1'b0;
      fifo_if.rd_i    = 1'b0;
      fifo_if.flush_i = 1'b0;
      check("used_words", fifo_if.used_words_o, m_cnt);
      check("full", fifo_if.full_o, m_cnt == DEPTH);
      check("almost_full", fifo_if.almost_full_o, m_cnt >= AFULL);
      check("almost_empty", fifo_if.almost_empty_o, m_cnt <= AEMPTY);
      if (m_cnt == 0) check("empty_at_zero", fifo_if.empty_o, 1);
`ifdef SC_FIFO_PROG_ERR_FLAGS_EN
      check("ovf", fifo_if.ovf_o, m_ovf);
      check("udf", fifo_if.udf_o, m_udf);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      //          wr rd data   cnt full empty af ae
      vecs[0]  = '{1, 0, 8'hA0, 1, 0, 1, 0, 1};
      vecs[1]  = '{1, 0, 8'hA1, 2, 0, 1, 0, 0};
      vecs[2]  = '{1, 0, 8'hA2, 3, 0, 0, 1, 0};
      vecs[3]  = '{1, 0, 8'hA3, 4, 0, 0, 1, 0};
      vecs[4]  = '{1, 0, 8'hA4, 5, 1, 0, 1, 0};
      vecs[5]  = '{1, 0, 8'hA5, 5, 1, 0, 1, 0};
      vecs[6]  = '{1, 1, 8'hA6, 4, 0, 0, 1, 0};
      vecs[7]  = '{0, 1, 8'h00, 3, 0, 0, 1, 0};
      vecs[8]  = '{0, 1, 8'h00, 2, 0, 0, 0, 0};
      vecs[9]  = '{0, 1, 8'h00, 1, 0, 0, 0, 1};
      vecs[10] = '{0, 1, 8'h00, 0, 0, 1, 0, 1};

      fifo_if.flush_i   = 1'b0;
      fifo_if.wr_i      = 1'b0;
      fifo_if.rd_i      = 1'b0;
      fifo_if.wr_data_i = '0;

      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst = 1'b0;

      // Fill to full, overfill, simultaneous wr/rd at full, then drain.
      for (int i = 0; i < 11; i++) begin
         cycle(vecs[i].wr, vecs[i].rd, 1'b0, vecs[i].data);
         check($sformatf("vec%0d_used", i), fifo_if.used_words_o, vecs[i].exp_cnt);
         check($sformatf("vec%0d_full", i), fifo_if.full_o, vecs[i].exp_full);
         check($sformatf("vec%0d_empty", i), fifo_if.empty_o, vecs[i].exp_empty);
         check($sformatf("vec%0d_afull", i), fifo_if.almost_full_o, vecs[i].exp_af);
         check($sformatf("vec%0d_aempty", i), fifo_if.almost_empty_o, vecs[i].exp_ae);
      end
      check("drain_scoreboard_empty", sb_q.size(), 0);

      // Continuous streaming of 20 words; no output bubble once data is visible.
      wr_cnt = 0;
      pops   = 0;
      seen   = 1'b0;
      for (int c = 0; c < 60 && (wr_cnt < 20 || m_cnt > 0); c++) begin
         bit do_wr;
         bit do_rd;
         do_wr = (wr_cnt < 20);
         do_rd = !fifo_if.empty_o;
         if (do_rd) pops++;
         cycle(do_wr, do_rd, 1'b0, DW'(8'h10 + wr_cnt));
         if (do_wr) wr_cnt++;
         if (!fifo_if.empty_o) seen = 1'b1;
         if (seen) check("stream_no_bubble", fifo_if.empty_o, m_cnt == 0);
      end
      check("stream_pops", pops, 20);

      // Flush with 3 words stored and a write in the same cycle.
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, DW'(8'hC0 + i));
      cycle(1'b0, 1'b0, 1'b0, '0);
      check("preflush_empty", fifo_if.empty_o, 0);
      cycle(1'b1, 1'b0, 1'b1, 8'hEE);
      check("flush_used", fifo_if.used_words_o, 0);
      check("flush_empty", fifo_if.empty_o, 1);
      check("flush_full", fifo_if.full_o, 0);
      repeat (3) cycle(1'b0, 1'b0, 1'b0, '0);
      check("flush_write_dropped_empty", fifo_if.empty_o, 1);
      check("flush_write_dropped_used", fifo_if.used_words_o, 0);
      cycle(1'b1, 1'b0, 1'b0, 8'h5A);
      repeat (2) cycle(1'b0, 1'b0, 1'b0, '0);
      check("postflush_visible", fifo_if.empty_o, 0);
      cycle(1'b0, 1'b1, 1'b0, '0);

      // Read at empty, fill, write at full, then flush.
      repeat (2) cycle(1'b0, 1'b0, 1'b0, '0);
      cycle(1'b0, 1'b1, 1'b0, '0);
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, DW'(8'h30 + i));
      cycle(1'b1, 1'b0, 1'b0, 8'hFF);
      check("overfill_used", fifo_if.used_words_o, 5);
`ifdef SC_FIFO_PROG_ERR_FLAGS_EN
      check("err_ovf_set", fifo_if.ovf_o, 1);
      check("err_udf_set", fifo_if.udf_o, 1);
      repeat (2) cycle(1'b0, 1'b0, 1'b0, '0);
      check("err_ovf_sticky", fifo_if.ovf_o, 1);
      check("err_udf_sticky", fifo_if.udf_o, 1);
`endif
      cycle(1'b0, 1'b0, 1'b1, '0);
`ifdef SC_FIFO_PROG_ERR_FLAGS_EN
      check("err_ovf_flushed", fifo_if.ovf_o, 0);
      check("err_udf_flushed", fifo_if.udf_o, 0);
`endif

      // Asynchronous reset mid-operation.
      for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0, DW'(8'h60 + i));
      repeat (2) cycle(1'b0, 1'b0, 1'b0, '0);
      rst = 1'b1;
      #2;
      check_reset_values("async_reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb_q.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
      cycle(1'b1, 1'b0, 1'b0, 8'h77);
      repeat (2) cycle(1'b0, 1'b0, 1'b0, '0);
      check("postreset_visible", fifo_if.empty_o, 0);
      cycle(1'b0, 1'b1, 1'b0, '0);
      check("postreset_drained", fifo_if.empty_o, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sc_fifo_prog.md
# sc_fifo_prog

Single-clock first-word-fall-through FIFO with a registered output stage. It generalises the team's single-clock FIFO with four additions: arbitrary (non-power-of-two) depth, programmable almost-full and almost-empty levels, a synchronous flush, and optional sticky overflow/underflow error flags. It sits between Avalon-MM DMA read/write engines and their streaming datapaths, where burst-size decisions depend on the fill level.

## Interface
- DATA_WIDTH, 8: word width in bits.
- DEPTH, 8: capacity in words; any value ≥ 2, need not be a power of two.
- AFULL_LVL, DEPTH-1: almost_full_o asserts when fill ≥ AFULL_LVL; legal range 1..DEPTH.
- AEMPTY_LVL, 1: almost_empty_o asserts when fill ≤ AEMPTY_LVL; legal range 0..DEPTH-1.
- CNT_WIDTH, $clog2(DEPTH+1): fill-counter width (derived; do not override).

Ports:
- clk_i  in  1  the single clock.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous clear.
- wr_i  in  1  write request.
- wr_data_i  in  DATA_WIDTH  write data.
- rd_i  in  1  read/pop request; acknowledges the current rd_data_o.
- rd_data_o  out  DATA_WIDTH  head word; valid while empty_o = 0.
- used_words_o  out  CNT_WIDTH  count of accepted words not yet popped.
- full_o  out  1  FIFO is full.
- empty_o  out  1  output register holds no valid word.
- almost_full_o  out  1  fill-level flag (see AFULL_LVL).
- almost_empty_o  out  1  fill-level flag (see AEMPTY_LVL).
- ovf_o  out  1  sticky overflow flag; exists only with the Configuration macro.
- udf_o  out  1  sticky underflow flag; exists only with the Configuration macro.

## Operation
- Accepted write: wr_req = wr_i & !full_o.
- Accepted read: rd_req = rd_i & !empty_o.
- Requests that are not accepted are dropped silently and leave no state change.
- Fill counter:
  - +1 on wr_req only.
  - −1 on rd_req only.
  - Unchanged when both occur in the same cycle.
  - used_words_o is this counter value.
- Storage: a RAM of DEPTH entries plus a one-word output register. The RAM read is synchronous.
- Refill: the output register is loaded from the RAM when the register is empty and the RAM holds data, or when rd_req occurs and the RAM holds data.
- After the last word is popped, empty_o asserts once the RAM is also empty.
- Write and read pointers:
  - Each increments on its own enable.
  - Each wraps from DEPTH-1 to 0, with an explicit compare rather than natural overflow.
- full_o: registered. It sets on the edge where the counter becomes DEPTH and clears on the first rd_req without a wr_req.
- Full with wr_i and rd_i together: the read is accepted, the write is dropped, and the count becomes DEPTH-1.
- Level flags: both are registered from the next counter value, so they track used_words_o in the same cycle.
  - almost_full_o = (count ≥ AFULL_LVL).
  - almost_empty_o = (count ≤ AEMPTY_LVL).
- flush_i has highest priority. On the next edge:
  - counter, pointers, output-valid, RAM-valid and full_o clear.
  - wr_i and rd_i in the same cycle are ignored.
  - rd_data_o keeps its stale value; it is don't-care while empty_o = 1.
  - The error flags are also cleared.

## Timing
- Reset values:
  - used_words_o = 0, full_o = 0, empty_o = 1.
  - almost_full_o = 0, almost_empty_o = 1.
  - ovf_o = 0, udf_o = 0.
  - rd_data_o = 0.
- Write latency into an empty FIFO: write accepted on edge N → RAM-valid on N+1 → empty_o falls and rd_data_o is valid after edge N+2.
- Consequence of that latency: used_words_o can be 1 or 2 while empty_o = 1.
- Read side: rd_data_o shows the head word combinationally from the register. A pop on edge N presents the next word after edge N+1 when the RAM holds data, with no bubble under continuous reads.
- Full with a simultaneous read and write: the read is honoured and the write is dropped, as specified under Operation.
- Reset asserted mid-operation: all state returns to its reset values immediately (asynchronous); RAM contents are not cleared.

## Configuration
- SC_FIFO_PROG_ERR_FLAGS_EN defined:
  - ovf_o sets on wr_i & full_o.
  - udf_o sets on rd_i & empty_o.
  - Both stay set until flush_i or rst_i.
- SC_FIFO_PROG_ERR_FLAGS_EN undefined: ovf_o, udf_o and their logic are absent from the port list.

## Structure
- Package sc_fifo_prog_pkg holds:
  - ptr_wrap function: increment with wrap at DEPTH-1.
  - flag-state typedef.
  - elaboration-time parameter-range checks.
- Sub-module sc_fifo_prog_ram: simple dual-port RAM with synchronous read and read-enable, DEPTH entries (non-power-of-two allowed), no reset on the array.

## Test plan
- DEPTH = 5, reset, then write 5 words A0..A4:
  - empty_o falls 2 clocks after the first write.
  - full_o rises on the 5th write, with used_words_o = 5.
  - A 6th write is dropped and used_words_o stays at 5.
- DEPTH = 5, continuous writes and reads over 20 words: output order is exact, no bubbles, and both pointers wrap 4→0 at least three times.
- Full FIFO with wr_i and rd_i together: the head word pops, the write is dropped, and used_words_o = 4.
- AFULL_LVL = 3, AEMPTY_LVL = 1, fill 0→5→0:
  - almost_full_o is 1 exactly while count ≥ 3.
  - almost_empty_o is 1 exactly while count ≤ 1.
- Flush with 3 words stored, with wr_i = 1 in the same cycle:
  - next cycle used_words_o = 0, empty_o = 1, full_o = 0.
  - the flushed write is not stored.
- With the macro defined: wr_i at full sets ovf_o; rd_i at empty sets udf_o; both stay set until flush_i clears them.
